hazard_ctrl_gen: RTL and testbench

Parametrised hazard/forwarding controller for the R→C→M→W integer pipeline.
- Generalises load-use handling to NUM_SRC read ports, a configurable load-data latency (LOAD_BUBBLES) and three forwarding sources (C, M, W).
- Adds a multi-cycle compute busy hold and a branch-redirect flush.
- Sits beside the register-read stage. It drives the fetch/IR stall, the R→C bubble/hold controls and the registered per-source forward selects consumed in C.

---
 rtl/hazard_ctrl_gen_if.sv | 71 +++++++
 rtl/hazard_ctrl_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_hazard_ctrl_gen.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_gen_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_gen_if
//   Bundle between the R->C->M->W pipeline and the hazard/forwarding
//   controller (hazard_ctrl_gen).
//
//   Pipeline status (pipeline -> controller):
//     rsAdr_R    NUM_SRC*REG_ADR_W  source addresses in R, source i at
//                                   [i*REG_ADR_W +: REG_ADR_W]
//     rsUsed_R   NUM_SRC            source i is actually read
//     rdAdr_C/M/W, RegWrite_C/M/W   destination address / write enable
//     MemLoad_C/M                   stage holds a load
//     Busy_C                        multi-cycle unit in C not done
//     Redirect_C                    taken branch/jump resolved in C
//   Controls (controller -> pipeline):
//     FwdSel_C   2*NUM_SRC          registered forward selects (0 none,
//                                   1 C, 2 M, 3 W)
//     StallPC, StallIR, FlushIR, FlushRC, HoldRC
//     StallCnt, FlushCnt            performance counters (0 if disabled)
//     dbg_state, dbg_cnt            load-stall FSM state and counter
//
//   Handshake: there is no valid/ready pair. Every status signal is sampled
//   on every rising clk edge and every control is level-significant for the
//   cycle in which it is asserted; the pipeline must obey the controls in
//   that same cycle.
//
//   master modport: pipeline side. slave modport: controller side.
// ---------------------------------------------------------------------------
interface hazard_ctrl_gen_if #(
  parameter int REG_ADR_W = 5,
  parameter int NUM_SRC   = 2
);
  logic [NUM_SRC*REG_ADR_W-1:0] rsAdr_R;
  logic [NUM_SRC-1:0]           rsUsed_R;
  logic [REG_ADR_W-1:0]         rdAdr_C;
  logic [REG_ADR_W-1:0]         rdAdr_M;
  logic [REG_ADR_W-1:0]         rdAdr_W;
  logic                         RegWrite_C;
  logic                         RegWrite_M;
  logic                         RegWrite_W;
  logic                         MemLoad_C;
  logic                         MemLoad_M;
  logic                         Busy_C;
  logic                         Redirect_C;

  logic [2*NUM_SRC-1:0]         FwdSel_C;
  logic                         StallPC;
  logic                         StallIR;
  logic                         FlushIR;
  logic                         FlushRC;
  logic                         HoldRC;
  logic [31:0]                  StallCnt;
  logic [31:0]                  FlushCnt;
  logic                         dbg_state;
  logic [1:0]                   dbg_cnt;

  modport master (
    output rsAdr_R, rsUsed_R, rdAdr_C, rdAdr_M, rdAdr_W,
           RegWrite_C, RegWrite_M, RegWrite_W, MemLoad_C, MemLoad_M,
           Busy_C, Redirect_C,
    input  FwdSel_C, StallPC, StallIR, FlushIR, FlushRC, HoldRC,
           StallCnt, FlushCnt, dbg_state, dbg_cnt
  );

  modport slave (
    input  rsAdr_R, rsUsed_R, rdAdr_C, rdAdr_M, rdAdr_W,
           RegWrite_C, RegWrite_M, RegWrite_W, MemLoad_C, MemLoad_M,
           Busy_C, Redirect_C,
    output FwdSel_C, StallPC, StallIR, FlushIR, FlushRC, HoldRC,
           StallCnt, FlushCnt, dbg_state, dbg_cnt
  );
endinterface

// File: rtl/hazard_ctrl_gen.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_gen
//   Hazard / forwarding controller for the R->C->M->W integer pipeline.
//   Sits beside the register-read stage. Detects RAW dependencies of up to
//   NUM_SRC read ports against the C, M and W destinations, produces the
//   registered forward selects used in C, inserts load-use bubbles
//   (LOAD_BUBBLES deep), holds R->C while a multi-cycle unit in C is busy
//   and flushes the wrong path on a branch redirect.
//
//   Priority: reset > Redirect_C > Busy_C > load-stall FSM > forwarding.
//
//   Ports:
//     clk    clock
//     reset  synchronous, active-high
//     hz     hazard_ctrl_gen_if.slave (see interface for signal list)
//
//   Parameters:
//     REG_ADR_W     register address width
//     NUM_SRC       number of checked source operands (1..3)
//     LOAD_BUBBLES  bubbles a consumer needs directly behind a load (1 or 2)
//
//   Build option:
//     HAZARD_PERF_CNT_EN  when defined, StallCnt/FlushCnt are saturating
//                         32-bit counters; otherwise they are constant 0.
// ---------------------------------------------------------------------------
module hazard_ctrl_gen #(
  parameter int REG_ADR_W    = 5,
  parameter int NUM_SRC      = 2,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_gen_if.slave hz
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_LWAIT = 1'b1;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_C    = 2'd1;
  localparam logic [1:0] FWD_M    = 2'd2;
  localparam logic [1:0] FWD_W    = 2'd3;

  localparam logic [1:0] LB_N = 2'(LOAD_BUBBLES);

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  logic [0:0]           state_q, state_d;
  logic [1:0]           cnt_q,   cnt_d;
  logic [2*NUM_SRC-1:0] fwd_q,   fwd_d;

  // -------------------------------------------------------------------------
  // Per-source match against C/M/W and load-use bubble requirement
  // -------------------------------------------------------------------------
  logic [2*NUM_SRC-1:0] fwd_match;
  logic [1:0]           need_n;
  logic [REG_ADR_W-1:0] src_adr;
  logic                 hit_c;
  logic                 hit_m;
  logic                 hit_w;

  always_comb begin
    fwd_match = '0;
    need_n    = 2'd0;
    src_adr   = '0;
    hit_c     = 1'b0;
    hit_m     = 1'b0;
    hit_w     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_adr = hz.rsAdr_R[i*REG_ADR_W +: REG_ADR_W];
      // Register 0 is hard-wired, so writes to it never create a dependency.
      hit_c = hz.rsUsed_R[i] && hz.RegWrite_C && (hz.rdAdr_C != '0) &&
              (src_adr == hz.rdAdr_C);
      hit_m = hz.rsUsed_R[i] && hz.RegWrite_M && (hz.rdAdr_M != '0) &&
              (src_adr == hz.rdAdr_M);
      hit_w = hz.rsUsed_R[i] && hz.RegWrite_W && (hz.rdAdr_W != '0) &&
              (src_adr == hz.rdAdr_W);

      // Youngest producer wins: its value supersedes the older ones.
      if (hit_c) begin
        fwd_match[2*i +: 2] = FWD_C;
      end else if (hit_m) begin
        fwd_match[2*i +: 2] = FWD_M;
      end else if (hit_w) begin
        fwd_match[2*i +: 2] = FWD_W;
      end else begin
        fwd_match[2*i +: 2] = FWD_NONE;
      end

      // Worst requirement over all sources decides the bubble count. With a
      // two-cycle load path a load already in M still lacks one cycle, but
      // only if no younger producer in C shadows it.
      if (hit_c && hz.MemLoad_C) begin
        if (need_n < LB_N) begin
          need_n = LB_N;
        end
      end else if ((LOAD_BUBBLES == 2) && !hit_c && hit_m && hz.MemLoad_M) begin
        if (need_n == 2'd0) begin
          need_n = 2'd1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control outputs and next-state
  // -------------------------------------------------------------------------
  logic stall_pc;
  logic stall_ir;
  logic flush_ir;
  logic flush_rc;
  logic hold_rc;

  always_comb begin
    stall_pc = 1'b0;
    stall_ir = 1'b0;
    flush_ir = 1'b0;
    flush_rc = 1'b0;
    hold_rc  = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    fwd_d    = fwd_q;

    if (reset) begin
      // Outputs stay quiet; reset abandons any load stall in progress.
      state_d = ST_RUN;
      cnt_d   = 2'd0;
      fwd_d   = '0;
    end else if (hz.Redirect_C) begin
      // The stalled consumer is on the wrong path, so any stall or hold is
      // dropped and the younger stages are killed instead.
      flush_ir = 1'b1;
      flush_rc = 1'b1;
      state_d  = ST_RUN;
      cnt_d    = 2'd0;
      fwd_d    = '0;
    end else if (hz.Busy_C) begin
      // Freeze R and C as they are; the load decision is re-taken when the
      // unit finishes, since the producer has not advanced.
      stall_pc = 1'b1;
      stall_ir = 1'b1;
      hold_rc  = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (need_n != 2'd0) begin
            stall_pc = 1'b1;
            stall_ir = 1'b1;
            flush_rc = 1'b1;
            fwd_d    = '0;
            if (need_n == 2'd2) begin
              state_d = ST_LWAIT;
              cnt_d   = 2'd0;
            end
          end else begin
            fwd_d = fwd_match;
          end
        end
        ST_LWAIT: begin
          // Producer is still moving toward M/W; no detection until it lands.
          stall_pc = 1'b1;
          stall_ir = 1'b1;
          flush_rc = 1'b1;
          fwd_d    = '0;
          if (cnt_q == 2'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
          fwd_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
      fwd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fwd_q   <= fwd_d;
    end
  end

  assign hz.FwdSel_C  = fwd_q;
  assign hz.StallPC   = stall_pc;
  assign hz.StallIR   = stall_ir;
  assign hz.FlushIR   = flush_ir;
  assign hz.FlushRC   = flush_rc;
  assign hz.HoldRC    = hold_rc;
  assign hz.dbg_state = state_q;
  assign hz.dbg_cnt   = cnt_q;

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // Saturate rather than wrap so long runs never under-report.
      if (stall_pc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (hz.Redirect_C && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign hz.StallCnt = stall_cnt_q;
  assign hz.FlushCnt = flush_cnt_q;
`else
  assign hz.StallCnt = 32'd0;
  assign hz.FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_gen
//   Two controllers (LOAD_BUBBLES=1 and =2) driven with identical pipeline
//   status. A bubble-count reference model tracks both.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_gen;
  localparam int AW = 5;
  localparam int NS = 2;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, limit 2000000 time units");
    $fatal(1);
  end

  // ---------------- stimulus variables ----------------
  logic [NS*AW-1:0] rs_adr;
  logic [NS-1:0]    rs_used;
  logic [AW-1:0]    rd_c, rd_m, rd_w;
  logic             we_c, we_m, we_w, ld_c, ld_m, busy, redir;

  hazard_ctrl_gen_if #(.REG_ADR_W(AW), .NUM_SRC(NS)) if1 ();
  hazard_ctrl_gen_if #(.REG_ADR_W(AW), .NUM_SRC(NS)) if2 ();

  assign if1.rsAdr_R = rs_adr;   assign if2.rsAdr_R = rs_adr;
  assign if1.rsUsed_R = rs_used; assign if2.rsUsed_R = rs_used;
  assign if1.rdAdr_C = rd_c;     assign if2.rdAdr_C = rd_c;
  assign if1.rdAdr_M = rd_m;     assign if2.rdAdr_M = rd_m;
  assign if1.rdAdr_W = rd_w;     assign if2.rdAdr_W = rd_w;
  assign if1.RegWrite_C = we_c;  assign if2.RegWrite_C = we_c;
  assign if1.RegWrite_M = we_m;  assign if2.RegWrite_M = we_m;
  assign if1.RegWrite_W = we_w;  assign if2.RegWrite_W = we_w;
  assign if1.MemLoad_C = ld_c;   assign if2.MemLoad_C = ld_c;
  assign if1.MemLoad_M = ld_m;   assign if2.MemLoad_M = ld_m;
  assign if1.Busy_C = busy;      assign if2.Busy_C = busy;
  assign if1.Redirect_C = redir; assign if2.Redirect_C = redir;

  hazard_ctrl_gen #(.REG_ADR_W(AW), .NUM_SRC(NS), .LOAD_BUBBLES(1)) dut1 (
    .clk(clk), .reset(reset), .hz(if1));
  hazard_ctrl_gen #(.REG_ADR_W(AW), .NUM_SRC(NS), .LOAD_BUBBLES(2)) dut2 (
    .clk(clk), .reset(reset), .hz(if2));

  // {StallPC, StallIR, FlushIR, FlushRC, HoldRC}
  wire [4:0] ctl1 = {if1.StallPC, if1.StallIR, if1.FlushIR, if1.FlushRC, if1.HoldRC};
  wire [4:0] ctl2 = {if2.StallPC, if2.StallIR, if2.FlushIR, if2.FlushRC, if2.HoldRC};

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Index 0: one-bubble controller, index 1: two-bubble controller.
  // m_rem = bubbles still owed for a load already detected.
  int          m_rem[2], n_rem[2];
  logic [3:0]  m_fwd[2], n_fwd[2];
  logic [31:0] m_scnt[2], n_scnt[2], m_fcnt[2], n_fcnt[2];
  logic [4:0]  e_ctl[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_fwd[k] = '0; m_scnt[k] = '0; m_fcnt[k] = '0;
    end
  end

  task automatic model_eval();
    logic [AW-1:0] p_adr[3];
    logic          p_we[3];
    p_adr[0] = rd_c; p_adr[1] = rd_m; p_adr[2] = rd_w;
    p_we[0]  = we_c; p_we[1]  = we_m; p_we[2]  = we_w;
    for (int k = 0; k < 2; k++) begin
      int lb;
      int need;
      logic [3:0] codes;
      logic st, fir, frc, hld;
      lb = k + 1; need = 0; codes = '0;
      for (int s = 0; s < NS; s++) begin
        logic [AW-1:0] src;
        int code;
        src  = rs_adr[s*AW +: AW];
        code = 0;
        // stages listed youngest first: first hit is the freshest value
        for (int sg = 0; sg < 3; sg++)
          if (code == 0 && rs_used[s] && p_we[sg] && p_adr[sg] != 0 && src == p_adr[sg])
            code = sg + 1;
        codes[2*s +: 2] = 2'(code);
        if (code == 1 && ld_c && need < lb) need = lb;
        if (code == 2 && ld_m && lb == 2 && need < 1) need = 1;
      end
      n_rem[k] = m_rem[k]; n_fwd[k] = m_fwd[k];
      n_scnt[k] = m_scnt[k]; n_fcnt[k] = m_fcnt[k];
      st = 0; fir = 0; frc = 0; hld = 0;
      if (reset) begin
        n_rem[k] = 0; n_fwd[k] = '0; n_scnt[k] = '0; n_fcnt[k] = '0;
      end else begin
        if (redir) begin
          fir = 1; frc = 1; n_rem[k] = 0; n_fwd[k] = '0;
        end else if (busy) begin
          st = 1; hld = 1;
        end else if (m_rem[k] > 0) begin
          st = 1; frc = 1; n_rem[k] = m_rem[k] - 1; n_fwd[k] = '0;
        end else if (need > 0) begin
          st = 1; frc = 1; n_rem[k] = need - 1; n_fwd[k] = '0;
        end else begin
          n_fwd[k] = codes;
        end
        if (PERF && st && m_scnt[k] != 32'hFFFF_FFFF) n_scnt[k] = m_scnt[k] + 1;
        if (PERF && redir && m_fcnt[k] != 32'hFFFF_FFFF) n_fcnt[k] = m_fcnt[k] + 1;
      end
      e_ctl[k] = {st, st, fir, frc, hld};
    end
  endtask

  // ---------------- driver tasks ----------------
  // half: mid-cycle sampling point. tick: clock edge, model commit,
  // then inputs may change.
  task automatic half();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = n_rem[k]; m_fwd[k] = n_fwd[k];
      m_scnt[k] = n_scnt[k]; m_fcnt[k] = n_fcnt[k];
    end
    #1;
  endtask

  task automatic set_idle();
    rs_adr = '0; rs_used = '0; rd_c = '0; rd_m = '0; rd_w = '0;
    we_c = 0; we_m = 0; we_w = 0; ld_c = 0; ld_m = 0; busy = 0; redir = 0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    half();
    tick();
    reset = 1'b0;
  endtask

  // C-stage load writing r5, consumed by source 0
  task automatic load_use_c();
    set_idle();
    rs_adr = {5'd0, 5'd5}; rs_used = 2'b01;
    rd_c = 5'd5; we_c = 1; ld_c = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    load_use_c();
    reset = 1'b1;
    half();
    if (ctl1 !== 5'b0) begin n_err++; $display("FAIL reset_ctl1: got %b expected %b", ctl1, 5'b0); end
    n_cmp++;
    if (ctl2 !== 5'b0) begin n_err++; $display("FAIL reset_ctl2: got %b expected %b", ctl2, 5'b0); end
    n_cmp++;
    tick();
    reset = 1'b0;
    set_idle();
    half();
    if (if1.FwdSel_C !== 4'b0) begin n_err++; $display("FAIL reset_fwd1: got %h expected 0", if1.FwdSel_C); end
    n_cmp++;
    if (if2.FwdSel_C !== 4'b0) begin n_err++; $display("FAIL reset_fwd2: got %h expected 0", if2.FwdSel_C); end
    n_cmp++;
    if ({if2.StallCnt, if2.FlushCnt} !== 64'd0) begin
      n_err++; $display("FAIL reset_cnt: got %h/%h expected 0/0", if2.StallCnt, if2.FlushCnt);
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_load_use_1();
    do_reset();
    load_use_c();
    half();
    if (ctl1 !== 5'b11010) begin n_err++; $display("FAIL lu1_stall: got %b expected %b", ctl1, 5'b11010); end
    n_cmp++;
    tick();
    we_c = 0; ld_c = 0; rd_c = 0; rd_m = 5'd5; we_m = 1; ld_m = 1;
    half();
    if (ctl1 !== 5'b0) begin n_err++; $display("FAIL lu1_release: got %b expected %b", ctl1, 5'b0); end
    n_cmp++;
    tick();
    half();
    if (if1.FwdSel_C !== 4'b0010) begin n_err++; $display("FAIL lu1_fwd_m: got %h expected 2", if1.FwdSel_C); end
    n_cmp++;
    tick();
  endtask

  task automatic test_load_use_2();
    do_reset();
    load_use_c();
    half();
    if (ctl2 !== 5'b11010) begin n_err++; $display("FAIL lu2_stall_a: got %b expected %b", ctl2, 5'b11010); end
    n_cmp++;
    tick();
    we_c = 0; ld_c = 0; rd_c = 0; rd_m = 5'd5; we_m = 1; ld_m = 1;
    half();
    if (ctl2 !== 5'b11010) begin n_err++; $display("FAIL lu2_stall_b: got %b expected %b", ctl2, 5'b11010); end
    n_cmp++;
    if ({if2.dbg_state, if2.dbg_cnt} !== 3'b100) begin
      n_err++; $display("FAIL lu2_lwait: got %b expected %b", {if2.dbg_state, if2.dbg_cnt}, 3'b100);
    end
    n_cmp++;
    tick();
    we_m = 0; ld_m = 0; rd_m = 0; rd_w = 5'd5; we_w = 1;
    half();
    if (ctl2 !== 5'b0) begin n_err++; $display("FAIL lu2_release: got %b expected %b", ctl2, 5'b0); end
    n_cmp++;
    tick();
    half();
    if (if2.FwdSel_C !== 4'b0011) begin n_err++; $display("FAIL lu2_fwd_w: got %h expected 3", if2.FwdSel_C); end
    n_cmp++;
    tick();
  endtask

  task automatic test_alu_forward();
    do_reset();
    rs_adr = {5'd7, 5'd7}; rs_used = 2'b11;
    rd_c = 5'd7; we_c = 1; rd_m = 5'd7; we_m = 1;
    half();
    if (ctl1 !== 5'b0 || ctl2 !== 5'b0) begin
      n_err++; $display("FAIL alu_nostall: got %b/%b expected 0/0", ctl1, ctl2);
    end
    n_cmp++;
    tick();
    rd_c = 5'd0; we_m = 0;
    half();
    if (if1.FwdSel_C !== 4'b0101) begin n_err++; $display("FAIL alu_fwd_c1: got %h expected 5", if1.FwdSel_C); end
    n_cmp++;
    if (if2.FwdSel_C !== 4'b0101) begin n_err++; $display("FAIL alu_fwd_c2: got %h expected 5", if2.FwdSel_C); end
    n_cmp++;
    tick();
    half();
    if (if1.FwdSel_C !== 4'b0000) begin n_err++; $display("FAIL alu_fwd_r0: got %h expected 0", if1.FwdSel_C); end
    n_cmp++;
    tick();
  endtask

  task automatic test_busy();
    do_reset();
    set_idle();
    rs_adr = {5'd0, 5'd5}; rs_used = 2'b01; rd_c = 5'd5; we_c = 1;
    half();
    tick();
    busy = 1; ld_c = 1;
    for (int c = 0; c < 4; c++) begin
      half();
      if (ctl1 !== 5'b11001) begin n_err++; $display("FAIL busy_ctl1[%0d]: got %b expected %b", c, ctl1, 5'b11001); end
      n_cmp++;
      if (ctl2 !== 5'b11001) begin n_err++; $display("FAIL busy_ctl2[%0d]: got %b expected %b", c, ctl2, 5'b11001); end
      n_cmp++;
      if (if1.FwdSel_C !== 4'b0001) begin n_err++; $display("FAIL busy_fwd[%0d]: got %h expected 1", c, if1.FwdSel_C); end
      n_cmp++;
      tick();
    end
    busy = 0;
    half();
    if (ctl1 !== 5'b11010) begin n_err++; $display("FAIL busy_then_load: got %b expected %b", ctl1, 5'b11010); end
    n_cmp++;
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    load_use_c();
    half();
    tick();
    we_c = 0; ld_c = 0; rd_c = 0; rd_m = 5'd5; we_m = 1; ld_m = 1; redir = 1;
    half();
    if (ctl2 !== 5'b00110) begin n_err++; $display("FAIL redir_ctl: got %b expected %b", ctl2, 5'b00110); end
    n_cmp++;
    tick();
    set_idle();
    half();
    if (ctl2 !== 5'b0) begin n_err++; $display("FAIL redir_run: got %b expected %b", ctl2, 5'b0); end
    n_cmp++;
    if (if2.FwdSel_C !== 4'b0) begin n_err++; $display("FAIL redir_fwd: got %h expected 0", if2.FwdSel_C); end
    n_cmp++;
    if (if2.FlushCnt !== (PERF ? 32'd1 : 32'd0)) begin
      n_err++; $display("FAIL redir_flushcnt: got %0d expected %0d", if2.FlushCnt, PERF ? 1 : 0);
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_reset_mid_lwait();
    do_reset();
    load_use_c();
    half();
    tick();
    reset = 1'b1;
    half();
    if (ctl2 !== 5'b0) begin n_err++; $display("FAIL rst_lwait_ctl: got %b expected %b", ctl2, 5'b0); end
    n_cmp++;
    tick();
    reset = 1'b0;
    set_idle();
    half();
    if (ctl2 !== 5'b0 || if2.FwdSel_C !== 4'b0) begin
      n_err++; $display("FAIL rst_lwait_run: got %b/%h expected 0/0", ctl2, if2.FwdSel_C);
    end
    n_cmp++;
    if ({if2.StallCnt, if2.FlushCnt} !== 64'd0) begin
      n_err++; $display("FAIL rst_lwait_cnt: got %h/%h expected 0/0", if2.StallCnt, if2.FlushCnt);
    end
    n_cmp++;
    tick();
    rs_adr = {5'd5, 5'd5}; rs_used = 2'b00; rd_c = 5'd5; we_c = 1; ld_c = 1;
    rd_m = 5'd5; we_m = 1;
    half();
    if (ctl1 !== 5'b0 || ctl2 !== 5'b0) begin
      n_err++; $display("FAIL unused_nostall: got %b/%b expected 0/0", ctl1, ctl2);
    end
    n_cmp++;
    tick();
    half();
    if (if1.FwdSel_C !== 4'b0 || if2.FwdSel_C !== 4'b0) begin
      n_err++; $display("FAIL unused_nofwd: got %h/%h expected 0/0", if1.FwdSel_C, if2.FwdSel_C);
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_random();
    logic [4:0]  a_ctl[2];
    logic [3:0]  a_fwd[2];
    logic [31:0] a_sc[2], a_fc[2];
    for (int c = 0; c < 800; c++) begin
      reset   = ($urandom_range(0, 49) == 0);
      rs_adr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rs_used = 2'($urandom_range(0, 3));
      rd_c = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3)); rd_w = 5'($urandom_range(0, 3));
      we_c = 1'($urandom_range(0, 1)); we_m = 1'($urandom_range(0, 1)); we_w = 1'($urandom_range(0, 1));
      ld_c = 1'($urandom_range(0, 1)); ld_m = 1'($urandom_range(0, 1));
      busy  = ($urandom_range(0, 5) == 0);
      redir = ($urandom_range(0, 11) == 0);
      half();
      a_ctl[0] = ctl1; a_ctl[1] = ctl2;
      a_fwd[0] = if1.FwdSel_C; a_fwd[1] = if2.FwdSel_C;
      a_sc[0] = if1.StallCnt; a_sc[1] = if2.StallCnt;
      a_fc[0] = if1.FlushCnt; a_fc[1] = if2.FlushCnt;
      for (int k = 0; k < 2; k++) begin
        if (a_ctl[k] !== e_ctl[k]) begin
          n_err++; $display("FAIL rnd_ctl lb%0d cyc%0d: got %b expected %b", k + 1, c, a_ctl[k], e_ctl[k]);
        end
        n_cmp++;
        if (a_fwd[k] !== m_fwd[k]) begin
          n_err++; $display("FAIL rnd_fwd lb%0d cyc%0d: got %h expected %h", k + 1, c, a_fwd[k], m_fwd[k]);
        end
        n_cmp++;
        if (a_sc[k] !== m_scnt[k] || a_fc[k] !== m_fcnt[k]) begin
          n_err++; $display("FAIL rnd_cnt lb%0d cyc%0d: got %0d/%0d expected %0d/%0d",
                            k + 1, c, a_sc[k], a_fc[k], m_scnt[k], m_fcnt[k]);
        end
        n_cmp++;
      end
      tick();
    end
    reset = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    set_idle();
    reset = 1'b1;
    test_reset();
    test_load_use_1();
    test_load_use_2();
    test_alu_forward();
    test_busy();
    test_redirect();
    test_reset_mid_lwait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
